streaming_unit: RTL and testbench
=================================

// Module: streaming_unit
// PURPOSE
//   D2Q9 lattice-Boltzmann streaming address generator for a square, periodic (torus) grid.
//   For one source cell (x,y) and nine lattice velocity vectors (cx_i,cy_i), it computes
//   the nine destination cell addresses that the post-collision populations are written to.
//   Sits between the collision stage and the distribution-memory write port; registered, 1-cycle latency.
// PARAMETERS
//   GRID_DIM       256                      total cell count; must be a square of a power of two
//                                           (side SIDE = 2**($clog2(GRID_DIM)/2), default 16)
//   ADDRESS_WIDTH  $clog2(GRID_DIM)+1 (=9)  width of coordinates, velocity components and addresses
// PORTS
//   clk              in   1                  single clock, rising edge
//   rst              in   1                  asynchronous, active-high reset
//   in_valid         in   1                  x/y/cx/cy carry a request this cycle
//   x                in   ADDRESS_WIDTH      signed source column (0 = west edge)
//   y                in   ADDRESS_WIDTH      signed source row (0 = north edge)
//   cx               in   9*ADDRESS_WIDTH    9 packed signed x-velocity components, lane i = bits [i*AW +: AW]
//   cy               in   9*ADDRESS_WIDTH    9 packed signed y-velocity components, same lane packing
//   out_valid        out  1                  write_addresses holds the result of a valid request
//   write_addresses  out  9*ADDRESS_WIDTH    9 packed unsigned destination addresses, lane i matches cx/cy lane i
// BEHAVIOUR
//   - Per lane i (all 9 in parallel, independent):
//       xs = x + cx_i, ys = y + cy_i (two's complement, at least ADDRESS_WIDTH+1 bits)
//       xd = xs mod SIDE, yd = ys mod SIDE, taken as low log2(SIDE) bits (true modulo for negatives)
//       addr_i = yd*SIDE + xd = {yd, xd}, zero-extended to ADDRESS_WIDTH (MSB always 0 when GRID_DIM=256)
//   - Periodic wrap at all four edges: -1 -> SIDE-1, SIDE -> 0; any signed x/y/c value is reduced modulo SIDE.
//   - Row-major addressing: address 0 = NW corner (0,0); address GRID_DIM-1 = SE corner.
//   - Latency: inputs sampled on the rising clk edge; write_addresses and out_valid update on that edge.
//     out_valid <= in_valid every cycle.
//   - write_addresses registers load on every edge where in_valid=1; they hold their value when in_valid=0.
//   - No backpressure; a new request is accepted every cycle (throughput 1 cell/cycle).
//   - Reset (async assert, sync deassert handled at system level): out_valid=0, write_addresses=0.
//     Reset mid-operation drops any in-flight result. First valid output appears 1 edge after the
//     first in_valid sampled with rst low.
//   - Lane convention used by the collision stage, lanes 8..0 as (cx,cy):
//     (0,0) (1,0) (0,-1) (-1,0) (0,1) (1,-1) (-1,-1) (-1,1) (1,1). The block itself is convention-agnostic.
// TESTING
//   1. NW corner: x=0,y=0, convention lanes, in_valid=1 -> next edge out_valid=1,
//      lanes 8..0 = 0,1,240,15,16,241,255,31,17.
//   2. SE corner: x=15,y=15 -> lanes 8..0 = 255,240,239,254,15,224,238,14,0.
//   3. Interior: x=5,y=7 -> lanes 8..0 = 117,118,101,116,133,102,100,132,134.
//   4. Reset: assert rst asynchronously mid-stream -> out_valid and write_addresses go to 0 immediately,
//      without waiting for a clock edge; after release, results resume 1 cycle after the next in_valid.
//   5. Hold: in_valid=0 with changing x/y -> write_addresses unchanged, out_valid=0.
//   6. Back-to-back: (0,0) then (15,15) on consecutive cycles -> results of tests 1 and 2
//      appear on consecutive cycles.

Source files
------------

// File: rtl/streaming_unit.sv
// streaming_unit: D2Q9 streaming address generator for a periodic square grid,
// mapping one source cell and nine velocity lanes to nine registered destination addresses.
module streaming_unit #(
    parameter int GRID_DIM      = 256,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ADDRESS_WIDTH-1:0]   x,
    input  logic [ADDRESS_WIDTH-1:0]   y,
    input  logic [9*ADDRESS_WIDTH-1:0] cx,
    input  logic [9*ADDRESS_WIDTH-1:0] cy,
    output logic                       out_valid,
    output logic [9*ADDRESS_WIDTH-1:0] write_addresses
);
    localparam int SB = $clog2(GRID_DIM) / 2;

    logic [9*ADDRESS_WIDTH-1:0] next_addr;

    for (genvar i = 0; i < 9; i++) begin : g_lane
        logic [ADDRESS_WIDTH-1:0] xs, ys;
        logic                     unused_hi;
        assign xs = x + cx[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign ys = y + cy[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        // Side is a power of two, so the low bits of the two's-complement sum are the true modulo.
        assign next_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = ADDRESS_WIDTH'({ys[SB-1:0], xs[SB-1:0]});
        assign unused_hi = ^{xs[ADDRESS_WIDTH-1:SB], ys[ADDRESS_WIDTH-1:SB]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            write_addresses <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) write_addresses <= next_addr;
        end
    end
endmodule

// File: tb/tb_streaming_unit.sv
// tb_streaming_unit: directed and random checks of streaming_unit against a
// scoreboard of spec constants and an integer-modulo reference model.
module tb_streaming_unit;
    localparam int AW = 9;
    localparam int W  = 9 * AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [AW-1:0] x = '0, y = '0;
    logic [W-1:0]  cx = '0, cy = '0;
    logic          out_valid;
    logic [W-1:0]  write_addresses;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb[$];
    logic [W-1:0] held = '0;

    int conv_x[8:0] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    int conv_y[8:0] = '{0, 0, -1, 0, 1, -1, -1, 1, 1};
    int cvx[8:0], cvy[8:0];

    int t1[8:0] = '{0, 1, 240, 15, 16, 241, 255, 31, 17};
    int t2[8:0] = '{255, 240, 239, 254, 15, 224, 238, 14, 0};
    int t3[8:0] = '{117, 118, 101, 116, 133, 102, 100, 132, 134};

    streaming_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .cx(cx), .cy(cy),
        .out_valid(out_valid), .write_addresses(write_addresses)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input int l[8:0]);
        logic [W-1:0] r = '0;
        for (int i = 0; i < 9; i++) r[i*AW +: AW] = AW'(l[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] model(input int xi, input int yi);
        logic [W-1:0] r = '0;
        for (int i = 0; i < 9; i++) begin
            int xd, yd;
            xd = ((xi + cvx[i]) % 16 + 16) % 16;
            yd = ((yi + cvy[i]) % 16 + 16) % 16;
            r[i*AW +: AW] = AW'(yd * 16 + xd);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vel(input bit rnd);
        for (int i = 0; i < 9; i++) begin
            cvx[i] = rnd ? int'($urandom_range(0, 510)) - 255 : conv_x[i];
            cvy[i] = rnd ? int'($urandom_range(0, 510)) - 255 : conv_y[i];
            cx[i*AW +: AW] = AW'(cvx[i]);
            cy[i*AW +: AW] = AW'(cvy[i]);
        end
    endtask

    // Called at a falling edge; drives one request and checks the result one cycle later.
    task automatic step(input string tag, input logic v, input int xi, input int yi, input logic [W-1:0] e);
        in_valid = v;
        x = AW'(xi);
        y = AW'(yi);
        if (v) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, W'(out_valid), W'(v));
        if (v && sb.size() > 0) held = sb.pop_front();
        check({tag, "_addr"}, write_addresses, held);
    endtask

    initial begin
        set_vel(1'b0);
        #1;
        check("reset_valid", W'(out_valid), '0);
        check("reset_addr", write_addresses, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        step("nw", 1'b1, 0, 0, pack(t1));
        step("se", 1'b1, 15, 15, pack(t2));
        step("interior", 1'b1, 5, 7, pack(t3));
        step("hold1", 1'b0, 3, 9, '0);
        step("hold2", 1'b0, 12, 1, '0);
        step("b2b_nw", 1'b1, 0, 0, pack(t1));
        step("b2b_se", 1'b1, 15, 15, pack(t2));

        in_valid = 1'b1;
        x = AW'(5);
        y = AW'(7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", W'(out_valid), '0);
        check("async_rst_addr", write_addresses, '0);
        sb.delete();
        held = '0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        step("post_rst_idle", 1'b0, 9, 9, '0);
        step("post_rst_nw", 1'b1, 0, 0, pack(t1));

        set_vel(1'b1);
        for (int k = 0; k < 12; k++) begin
            int xi, yi;
            xi = int'($urandom_range(0, 511)) - 256;
            yi = int'($urandom_range(0, 511)) - 256;
            step("random", 1'b1, xi, yi, model(xi, yi));
        end
        step("random_hold", 1'b0, 1, 2, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
